// File: rtl/button_conditioner.sv
// Synchronises and debounces raw buttons and DIP switches, then emits one pulse per button press.
// Define BTN_AUTOREPEAT_EN to add a timed repeat-pulse train while a button is held.
module button_conditioner #(
    parameter int NUM_BTN         = 2,
    parameter int NUM_SW          = 4,
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [NUM_SW-1:0]  sw_raw,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_SW-1:0]  sw_stable
);

    localparam int NUM_IN = NUM_BTN + NUM_SW;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param
        $error("button_conditioner: timing parameters must be >= 2");
    end

    logic [NUM_IN-1:0]  in_log;
    logic [NUM_IN-1:0]  sync1_q;
    logic [NUM_IN-1:0]  sync2_q;
    logic [NUM_IN-1:0]  stable_q;
    logic [NUM_IN-1:0]  stable_d;
    logic [DB_W-1:0]    db_cnt_q [NUM_IN];
    logic [DB_W-1:0]    db_cnt_d [NUM_IN];
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] pulse_d;
    logic [NUM_BTN-1:0] btn_pulse_q;

    // Buttons are flipped to 1 = pressed before synchronising so reset (0) means released.
    assign in_log = {sw_raw, (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw};

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NUM_IN; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign press = stable_d[NUM_BTN-1:0] & ~stable_q[NUM_BTN-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            btn_pulse_q <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= in_log;
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            btn_pulse_q <= pulse_d;
            for (int i = 0; i < NUM_IN; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0]   rpt_cnt_q [NUM_BTN];
    logic [RPT_W-1:0]   rpt_cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] rpt_first_q;
    logic [NUM_BTN-1:0] rpt_first_d;
    logic [NUM_BTN-1:0] held;
    logic [NUM_BTN-1:0] rpt_hit;

    // held needs both cycles high so the falling cycle can never emit a repeat.
    always_comb begin
        rpt_first_d = rpt_first_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            held[i]    = stable_d[i] & stable_q[i];
            rpt_hit[i] = held[i] &&
                         (rpt_cnt_q[i] == (rpt_first_q[i] ? RPT_DELAY_LAST : RPT_PERIOD_LAST));
            if (press[i] || !held[i] || rpt_hit[i]) begin
                rpt_cnt_d[i] = '0;
            end else begin
                rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
            end
            if (press[i]) begin
                rpt_first_d[i] = 1'b1;
            end else if (rpt_hit[i]) begin
                rpt_first_d[i] = 1'b0;
            end
        end
    end

    assign pulse_d = press | rpt_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_first_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                rpt_cnt_q[i] <= '0;
            end
        end else begin
            rpt_first_q <= rpt_first_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                rpt_cnt_q[i] <= rpt_cnt_d[i];
            end
        end
    end
`else
    assign pulse_d = press;
`endif

    assign btn_pulse = btn_pulse_q;
    assign btn_level = stable_q[NUM_BTN-1:0];
    assign sw_stable = stable_q[NUM_IN-1:NUM_BTN];

endmodule
